// File: rtl/nextasic_pkg.sv
// Shared monitor-link constants and the transmit FSM state type.
package nextasic_pkg;

  localparam int unsigned MON_FRAME_W     = 40;
  localparam logic        MON_IDLE_LEVEL  = 1'b0;
  localparam logic        MON_START_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_GAP
  } tx_state_e;

endpackage

// File: rtl/mon_frame_sender_if.sv
// Frame push handshake between core logic and the monitor frame sender.
interface mon_frame_sender_if;
  import nextasic_pkg::*;

  logic [MON_FRAME_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/mon_tx_fifo.sv
// Synchronous frame FIFO with extra-MSB pointers for full/empty detection.
module mon_tx_fifo
  import nextasic_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = MON_FRAME_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wr_data_i,
  output logic         full_o,
  input  logic         pop_i,
  output logic [W-1:0] rd_data_o,
  output logic         empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         push_ok, pop_ok;

  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign push_ok   = push_i & ~full_o;
  assign pop_ok    = pop_i & ~empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for accepted pushes and pops.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  // Pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset since the pointers gate reads.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/mon_frame_sender.sv
// Monitor link transmitter: buffers 40-bit frames and serialises them MSB first
// as start bit, data, optional parity, then a forced idle gap.
// Optional feature macro: MON_TX_PARITY_EN adds an even-parity bit after data[0].
module mon_frame_sender
  import nextasic_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             mon_clk,
  input  logic             reset,
  mon_frame_sender_if.slave in_if,
  input  logic             tx_enable,
  output logic             from_mon,
  output logic             busy,
  output logic [CNT_W-1:0] frames_sent
);

  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  tx_state_e              state_q, state_d;
  logic [MON_FRAME_W-1:0] shift_q, shift_d;
  logic [5:0]             bit_q, bit_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [CNT_W-1:0]       frames_sent_q, frames_sent_d;
  logic                   from_mon_q, from_mon_d;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic [MON_FRAME_W-1:0] fifo_data;
  logic                   launch, enter_gap;
`ifdef MON_TX_PARITY_EN
  logic                   par_q, par_d;
`endif

  mon_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (MON_FRAME_W)
  ) u_fifo (
    .clk_i     (mon_clk),
    .rst_i     (reset),
    .push_i    (in_if.in_valid),
    .wr_data_i (in_if.in_data),
    .full_o    (fifo_full),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_data),
    .empty_o   (fifo_empty)
  );

  assign in_if.in_ready = ~fifo_full;
  assign from_mon       = from_mon_q;
  assign busy           = (state_q != TX_IDLE) || !fifo_empty;
  assign frames_sent    = frames_sent_q;

  // Next state and next line level; from_mon_d is the level shown during the next state,
  // so a frame launch from IDLE or the last GAP cycle drives the start bit directly.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_d         = bit_q;
    gap_d         = gap_q;
    frames_sent_d = frames_sent_q;
    from_mon_d    = MON_IDLE_LEVEL;
    fifo_pop      = 1'b0;
    enter_gap     = 1'b0;
`ifdef MON_TX_PARITY_EN
    par_d         = par_q;
`endif
    launch = tx_enable && !fifo_empty &&
             ((state_q == TX_IDLE) || ((state_q == TX_GAP) && (gap_q == '0)));

    case (state_q)
      TX_IDLE: ;
      TX_START: begin
        state_d    = TX_DATA;
        from_mon_d = shift_q[MON_FRAME_W-1];
        shift_d    = shift_q << 1;
        bit_d      = 6'(MON_FRAME_W - 1);
      end
      TX_DATA: begin
        if (bit_q == 6'd0) begin
`ifdef MON_TX_PARITY_EN
          state_d    = TX_PARITY;
          from_mon_d = par_q;
`else
          enter_gap  = 1'b1;
`endif
        end else begin
          from_mon_d = shift_q[MON_FRAME_W-1];
          shift_d    = shift_q << 1;
          bit_d      = bit_q - 6'd1;
        end
      end
`ifdef MON_TX_PARITY_EN
      TX_PARITY: enter_gap = 1'b1;
`endif
      TX_GAP: begin
        if (gap_q == '0) state_d = TX_IDLE;
        else             gap_d   = gap_q - GW'(1);
      end
      default: state_d = TX_IDLE;
    endcase

    if (enter_gap) begin
      state_d       = TX_GAP;
      gap_d         = GW'(GAP_CYCLES - 1);
      frames_sent_d = frames_sent_q + CNT_W'(1);
    end

    if (launch) begin
      fifo_pop   = 1'b1;
      shift_d    = fifo_data;
      state_d    = TX_START;
      from_mon_d = MON_START_LEVEL;
`ifdef MON_TX_PARITY_EN
      par_d      = ^fifo_data;
`endif
    end
  end

  // State, datapath and registered line output.
  always_ff @(posedge mon_clk or posedge reset) begin
    if (reset) begin
      state_q       <= TX_IDLE;
      shift_q       <= '0;
      bit_q         <= '0;
      gap_q         <= '0;
      frames_sent_q <= '0;
      from_mon_q    <= MON_IDLE_LEVEL;
`ifdef MON_TX_PARITY_EN
      par_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bit_q         <= bit_d;
      gap_q         <= gap_d;
      frames_sent_q <= frames_sent_d;
      from_mon_q    <= from_mon_d;
`ifdef MON_TX_PARITY_EN
      par_q         <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_mon_frame_sender.sv
// Self-checking bench for mon_frame_sender: expected line waveforms are built
// from the frame format (start, data MSB first, optional parity, idle gap).
module tb_mon_frame_sender;
  import nextasic_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned GAP   = 2;
  localparam int unsigned CW    = 16;
`ifdef MON_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned FL = 1 + MON_FRAME_W + PAR + GAP;

  logic          mon_clk = 1'b0;
  logic          reset;
  logic          tx_enable;
  logic          from_mon;
  logic          busy;
  logic [CW-1:0] frames_sent;

  mon_frame_sender_if bus();

  mon_frame_sender #(
    .FIFO_DEPTH (DEPTH),
    .GAP_CYCLES (GAP),
    .CNT_W      (CW)
  ) dut (
    .mon_clk     (mon_clk),
    .reset       (reset),
    .in_if       (bus),
    .tx_enable   (tx_enable),
    .from_mon    (from_mon),
    .busy        (busy),
    .frames_sent (frames_sent)
  );

  always #5 mon_clk = ~mon_clk;

  int unsigned  vectors = 0;
  int unsigned  miscompares = 0;
  logic [255:0] got_v, exp_v;
  logic [39:0]  model_q[$];
  logic [CW-1:0] exp_cnt;

  task automatic tick();
    @(posedge mon_clk);
    #1;
  endtask

  // Sample the line n times, one sample per cycle, appending to got_v.
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      got_v = {got_v[254:0], from_mon};
      tick();
    end
  endtask

  // Append one frame's line waveform to exp_v.
  task automatic model_frame(input logic [39:0] d);
    logic [255:0] f;
    f = '0;
    f[MON_FRAME_W:0] = {1'b1, d};
    if (PAR != 0) f = {f[254:0], ^d};
    f = f << GAP;
    exp_v = (exp_v << FL) | f;
  endtask

  task automatic push(input logic [39:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
  endtask

  function automatic logic [39:0] rand40();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[39:0];
  endfunction

  task automatic test_reset();
    reset = 1'b1; tx_enable = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) tick();
    vectors++; if (from_mon !== 1'b0) begin miscompares++; $display("FAIL reset_from_mon: got %b expected 0", from_mon); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (frames_sent !== '0) begin miscompares++; $display("FAIL reset_count: got %h expected 0", frames_sent); end
    reset = 1'b0;
    tick();
    model_q.delete();
    exp_cnt = '0;
  endtask

  // Single frames into an idle sender; also checks start-bit latency.
  task automatic test_single();
    logic [39:0] pats[4];
    pats[0] = 40'h80_0000_0001; pats[1] = 40'h00_0000_0007;
    pats[2] = rand40();         pats[3] = rand40();
    tx_enable = 1'b1;
    foreach (pats[k]) begin
      push(pats[k]);
      vectors++; if (from_mon !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_pre_start: got line %b busy %b expected line 0 busy 1", from_mon, busy); end
      tick();
      got_v = '0; exp_v = '0;
      model_frame(pats[k]);
      capture(FL);
      exp_cnt = exp_cnt + 1'b1;
      vectors++; if (got_v !== exp_v) begin miscompares++; $display("FAIL single_stream: got %h expected %h", got_v, exp_v); end
      vectors++; if (frames_sent !== exp_cnt) begin miscompares++; $display("FAIL single_count: got %h expected %h", frames_sent, exp_cnt); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    end
  endtask

  // Fill the FIFO, attempt pushes while full (also with a concurrent pop), then drain.
  task automatic test_back_to_back();
    logic [39:0] d;
    tx_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 40'hA5A5A5A5A5 : rand40();
      vectors++; if (bus.in_ready !== (model_q.size() < DEPTH)) begin miscompares++; $display("FAIL b2b_ready_fill: got %b expected 1", bus.in_ready); end
      push(d);
      if (model_q.size() < DEPTH) model_q.push_back(d);
    end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_full: got %b expected 0", bus.in_ready); end
    push(rand40());
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_drop: got %b expected 0", bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_data = rand40(); tx_enable = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_pop: got %b expected 1", bus.in_ready); end
    got_v = '0; exp_v = '0;
    while (model_q.size() > 0) begin model_frame(model_q.pop_front()); exp_cnt = exp_cnt + 1'b1; end
    capture(4 * FL);
    vectors++; if (got_v !== exp_v) begin miscompares++; $display("FAIL b2b_stream: got %h expected %h", got_v, exp_v); end
    vectors++; if (frames_sent !== exp_cnt) begin miscompares++; $display("FAIL b2b_count: got %h expected %h", frames_sent, exp_cnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_hold_enable();
    logic [39:0] d;
    tx_enable = 1'b0;
    for (int i = 0; i < 2; i++) begin d = rand40(); push(d); model_q.push_back(d); end
    got_v = '0;
    capture(20);
    vectors++; if (got_v !== '0) begin miscompares++; $display("FAIL hold_line_idle: got %h expected 0", got_v); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL hold_busy: got %b expected 1", busy); end
    tx_enable = 1'b1;
    tick();
    got_v = '0; exp_v = '0;
    while (model_q.size() > 0) begin model_frame(model_q.pop_front()); exp_cnt = exp_cnt + 1'b1; end
    capture(2 * FL);
    vectors++; if (got_v !== exp_v) begin miscompares++; $display("FAIL hold_stream: got %h expected %h", got_v, exp_v); end
    vectors++; if (frames_sent !== exp_cnt) begin miscompares++; $display("FAIL hold_count: got %h expected %h", frames_sent, exp_cnt); end
  endtask

  // tx_enable falls mid-frame: the frame and its gap finish, then the line idles.
  task automatic test_enable_drop();
    logic [39:0] d1, d2;
    d1 = rand40(); d2 = rand40();
    tx_enable = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = d1; tick();
    bus.in_data = d2; tick();
    bus.in_valid = 1'b0;
    got_v = '0; exp_v = '0;
    capture(10);
    tx_enable = 1'b0;
    capture(FL - 10 + 20);
    model_frame(d1);
    exp_v = exp_v << 20;
    exp_cnt = exp_cnt + 1'b1;
    vectors++; if (got_v !== exp_v) begin miscompares++; $display("FAIL drop_stream: got %h expected %h", got_v, exp_v); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL drop_busy: got %b expected 1", busy); end
    vectors++; if (frames_sent !== exp_cnt) begin miscompares++; $display("FAIL drop_count: got %h expected %h", frames_sent, exp_cnt); end
    tx_enable = 1'b1;
    tick();
    got_v = '0; exp_v = '0;
    model_frame(d2);
    capture(FL);
    exp_cnt = exp_cnt + 1'b1;
    vectors++; if (got_v !== exp_v) begin miscompares++; $display("FAIL drop_resume_stream: got %h expected %h", got_v, exp_v); end
  endtask

  // Reset asserted while data bit 20 is on the line.
  task automatic test_reset_midframe();
    logic [39:0] d1;
    d1 = rand40() | (40'd1 << 20);
    tx_enable = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = d1; tick();
    bus.in_data = rand40(); tick();
    bus.in_data = rand40(); tick();
    bus.in_valid = 1'b0;
    repeat (19) tick();
    vectors++; if (from_mon !== 1'b1) begin miscompares++; $display("FAIL rst_mid_bit20: got %b expected 1", from_mon); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (from_mon !== 1'b0) begin miscompares++; $display("FAIL rst_mid_line: got %b expected 0", from_mon); end
    vectors++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_fifo: got busy %b ready %b expected busy 0 ready 1", busy, bus.in_ready); end
    vectors++; if (frames_sent !== '0) begin miscompares++; $display("FAIL rst_mid_count: got %h expected 0", frames_sent); end
    tick();
    reset = 1'b0;
    model_q.delete();
    exp_cnt = '0;
    got_v = '0;
    capture(60);
    vectors++; if (got_v !== '0) begin miscompares++; $display("FAIL rst_mid_idle_after: got %h expected 0", got_v); end
    vectors++; if (busy !== 1'b0 || frames_sent !== exp_cnt) begin miscompares++; $display("FAIL rst_mid_state_after: got busy %b count %h expected busy 0 count %h", busy, frames_sent, exp_cnt); end
  endtask

  // Random bursts of 1..4 frames pushed on consecutive cycles with tx_enable high.
  task automatic test_random();
    logic [39:0] f[4];
    int unsigned n;
    for (int it = 0; it < 6; it++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < 4; j++) f[j] = rand40();
      tx_enable = 1'b1;
      got_v = '0; exp_v = '0;
      for (int j = 0; j < int'(n); j++) begin model_frame(f[j]); exp_cnt = exp_cnt + 1'b1; end
      push(f[0]);
      for (int j = 0; j < int'(n * FL); j++) begin
        if (j + 1 < int'(n)) begin bus.in_valid = 1'b1; bus.in_data = f[j + 1]; end
        else bus.in_valid = 1'b0;
        tick();
        got_v = {got_v[254:0], from_mon};
      end
      tick();
      vectors++; if (got_v !== exp_v) begin miscompares++; $display("FAIL rand_stream: got %h expected %h", got_v, exp_v); end
      vectors++; if (frames_sent !== exp_cnt || busy !== 1'b0) begin miscompares++; $display("FAIL rand_count_busy: got %h/%b expected %h/0", frames_sent, busy, exp_cnt); end
      repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  // Counter wrap: preload to all-ones, then send one frame.
  task automatic test_wrap();
    logic [39:0] d;
    force dut.frames_sent_q = '1;
    tick();
    release dut.frames_sent_q;
    tick();
    exp_cnt = '1;
    vectors++; if (frames_sent !== exp_cnt) begin miscompares++; $display("FAIL wrap_preload: got %h expected %h", frames_sent, exp_cnt); end
    d = rand40();
    tx_enable = 1'b1;
    push(d);
    tick();
    got_v = '0; exp_v = '0;
    model_frame(d);
    capture(FL);
    exp_cnt = exp_cnt + 1'b1;
    vectors++; if (got_v !== exp_v) begin miscompares++; $display("FAIL wrap_stream: got %h expected %h", got_v, exp_v); end
    vectors++; if (frames_sent !== exp_cnt) begin miscompares++; $display("FAIL wrap_count: got %h expected %h", frames_sent, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold_enable();
    test_enable_drop();
    test_reset_midframe();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
